// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Brief    : Saturating 40-bit block accumulator behind the 16x16 multiplier.
//            Sums a programmable number of products, then holds the sum on a
//            valid/ready output until it is taken.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  len,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_len_q;
    logic               r_out_valid;
    logic               r_overflow;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_target;
    logic [ACC_W:0]     w_sum;
    logic               w_last;

    assign in_ready  = (r_state == ST_ACCUM) & rst_n;
    assign w_accept  = in_valid & in_ready & ~clear;

    // A zero length would never terminate the block, so it counts as one.
    assign w_len_eff = (len == '0) ? LEN_W'(1) : len;
    assign w_target  = (r_count == '0) ? w_len_eff : r_len_q;
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, product};
    assign w_last    = ({1'b0, r_count} + (LEN_W + 1)'(1)) == {1'b0, w_target};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_len_q     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_count == '0) begin
                            r_len_q <= w_len_eff;
                        end
                        // Clamp on carry-out; overflow stays set for the block.
                        if (w_sum[ACC_W]) begin
                            r_acc      <= '1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        if (w_last) begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_count     <= '0;
                        end else begin
                            r_count <= r_count + LEN_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign acc_out   = r_acc;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
